uart16550_seq: RTL and testbench

- Wishbone master that sequences one uart_top (UART16550) instance: it programs the divisor and line control after reset, then polls the UART.
- Moves bytes between a valid/ready byte-stream interface and the UART's THR/RBR registers.
- Sits between SoC logic or the bench and the UART slave port, in place of a CPU driving the UART by hand.
- Owns the UART's Wishbone slave port exclusively.

---
 rtl/uart16550_seq.sv | 152 +++++++++++++++
 tb/tb_uart16550_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart16550_seq.sv
// uart16550_seq: Wishbone master that initialises a UART16550, then polls LSR and moves bytes between a valid/ready stream and THR/RBR.
//   wb_clk_i, wb_rst_n_i               clock, asynchronous active-low reset
//   wb_adr_o/dat_o/sel_o/cyc_o/stb_o/we_o, wb_dat_i/ack_i   Wishbone master port to the UART
//   init_done_o                        configuration written
//   tx_data_i/tx_valid_i/tx_ready_o    byte stream towards the UART transmitter
//   rx_data_o/rx_valid_o/rx_ready_i    byte stream from the UART receiver
//   overrun_o, timeout_o               sticky error flags
//   Optional macro UART16550_SEQ_ACK_TIMEOUT_EN: abandon and retry a bus cycle after ACK_TIMEOUT cycles without ack.
module uart16550_seq #(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0] LCR_VALUE = 8'h03,
  parameter logic [7:0] FCR_VALUE = 8'h07,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  output logic        init_done_o,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        overrun_o,
  output logic        timeout_o
);
  typedef enum logic [3:0] {
    INIT_LCR1, INIT_DLL, INIT_DLM, INIT_LCR2, INIT_FCR, IDLE, POLL, RD_RBR, WR_THR
  } state_t;
  state_t state_q, state_d, nxt;
  logic cyc_q, cyc_d, we_q, we_d, s_we, ack;
  logic [4:0] adr_q, adr_d, s_adr;
  logic [7:0] dat_q, dat_d, s_dat, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, overrun_q, overrun_d, init_done_q, init_done_d;
  logic unused_dat;
  assign unused_dat = ^wb_dat_i[31:8];
`ifdef UART16550_SEQ_ACK_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  assign timeout_o = timeout_q;
`else
  logic unused_to;
  assign unused_to = ACK_TIMEOUT[0];
  assign timeout_o = 1'b0;
`endif
  always_comb begin
    s_we = 1'b1;
    s_adr = 5'd0;
    s_dat = 8'h00;
    nxt = IDLE;
    case (state_q)
      INIT_LCR1: begin s_adr = 5'd3; s_dat = LCR_VALUE | 8'h80; nxt = INIT_DLL; end
      INIT_DLL:  begin s_dat = DIVISOR[7:0]; nxt = INIT_DLM; end
      INIT_DLM:  begin s_adr = 5'd1; s_dat = DIVISOR[15:8]; nxt = INIT_LCR2; end
      INIT_LCR2: begin s_adr = 5'd3; s_dat = LCR_VALUE; nxt = INIT_FCR; end
      INIT_FCR:  begin s_adr = 5'd2; s_dat = FCR_VALUE; nxt = IDLE; end
      // RX wins over TX; only one data access follows each poll
      POLL: begin
        s_we = 1'b0;
        s_adr = 5'd5;
        nxt = (wb_dat_i[0] && !rx_valid_q) ? RD_RBR : (wb_dat_i[5] && tx_valid_i) ? WR_THR : IDLE;
      end
      RD_RBR: s_we = 1'b0;
      WR_THR: s_dat = tx_data_i;
      default: nxt = POLL;
    endcase
    ack = cyc_q & wb_ack_i;
    state_d = state_q;
    cyc_d = cyc_q;
    we_d = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
`ifdef UART16550_SEQ_ACK_TIMEOUT_EN
    cnt_d = cnt_q;
    timeout_d = timeout_q;
`endif
    // a cycle only starts when cyc is low, which guarantees the idle gap after every ack
    if (state_q == IDLE) state_d = POLL;
    else if (!cyc_q) begin
      cyc_d = 1'b1;
      we_d = s_we;
      adr_d = s_adr;
      dat_d = s_dat;
`ifdef UART16550_SEQ_ACK_TIMEOUT_EN
      cnt_d = 16'd0;
`endif
    end else if (wb_ack_i) begin
      cyc_d = 1'b0;
      state_d = nxt;
    end
`ifdef UART16550_SEQ_ACK_TIMEOUT_EN
    else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
      cyc_d = 1'b0;
      timeout_d = 1'b1;
    end else cnt_d = cnt_q + 16'd1;
`endif
    overrun_d = overrun_q | (ack && state_q == POLL && wb_dat_i[1]);
    init_done_d = init_done_q | (ack && state_q == INIT_FCR);
    rx_valid_d = (ack && state_q == RD_RBR) | (rx_valid_q & ~rx_ready_i);
    rx_data_d = (ack && state_q == RD_RBR) ? wb_dat_i[7:0] : rx_data_q;
    tx_ready_o = ack && state_q == WR_THR;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= INIT_LCR1;
      cyc_q <= 1'b0;
      we_q <= 1'b0;
      adr_q <= 5'd0;
      dat_q <= 8'h00;
      rx_data_q <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      init_done_q <= 1'b0;
`ifdef UART16550_SEQ_ACK_TIMEOUT_EN
      cnt_q <= 16'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      we_q <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q <= overrun_d;
      init_done_q <= init_done_d;
`ifdef UART16550_SEQ_ACK_TIMEOUT_EN
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end
  assign wb_adr_o = adr_q;
  assign wb_dat_o = {24'h0, dat_q};
  assign wb_sel_o = {3'b000, cyc_q};
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o = we_q;
  assign init_done_o = init_done_q;
  assign rx_data_o = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign overrun_o = overrun_q;
endmodule

// File: tb/tb_uart16550_seq.sv
// tb_uart16550_seq: scoreboard bench for uart16550_seq against a behavioural UART register model.
module tb_uart16550_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [4:0] adr;
  logic [31:0] dat_o, dat_i;
  logic [3:0] sel;
  logic cyc, stb, we, ack;
  logic init_done, tx_ready, rx_valid, overrun, timeout;
  logic tx_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00, rx_data;

  uart16550_seq dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i),
    .wb_sel_o(sel), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_ack_i(ack),
    .init_done_o(init_done), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .overrun_o(overrun), .timeout_o(timeout)
  );

  int n_pass = 0, n_total = 0;
  logic [12:0] exp_wr[$];
  logic [7:0] exp_rx[$], rx_fifo[$], thr_log[$], tx_sent[$];
  int acc_log[$];
  bit no_ack = 0, thre = 1, force_oe = 0, dlab = 0, prev_txr = 0, fcr_seen = 0;
  int rbr_cnt = 0, early_reads = 0, txr_cnt = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // UART register model: DLAB-aware THR/RBR, LSR built from FIFO state, random ack latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
      dat_i <= 32'h0;
      dlab <= 1'b0;
    end else if (ack) begin
      ack <= 1'b0;
      if (cyc && we && adr == 5'd3) dlab <= dat_o[7];
      if (cyc && we && adr == 5'd0 && !dlab) thr_log.push_back(dat_o[7:0]);
      if (cyc && !we && adr == 5'd0 && !dlab && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
    end else if (cyc && stb && !no_ack && $urandom_range(0, 2) != 0) begin
      ack <= 1'b1;
      dat_i <= {24'h0, adr == 5'd5 ? {2'b00, thre, 3'b000, force_oe, rx_fifo.size() > 0}
                                   : (adr == 5'd0 && rx_fifo.size() > 0 ? rx_fifo[0] : 8'h00)};
    end
  end

  // monitor: pops the scoreboard whenever the DUT completes an access or hands over a byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (fcr_seen) begin
        check("init_done_after_fcr", 32'(init_done), 1);
        fcr_seen = 0;
      end
      if (cyc && stb && ack) begin
        if (we) begin
          if (exp_wr.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got adr %0d dat %0h expected none", adr, dat_o[7:0]);
          end else check("bus_write", 32'({adr, dat_o[7:0]}), 32'(exp_wr.pop_front()));
          check("sel", 32'(sel), 1);
          check("dat_hi", 32'(dat_o[31:8]), 0);
          if (adr == 5'd2) begin
            check("init_done_at_fcr_ack", 32'(init_done), 0);
            fcr_seen = 1;
          end
        end else begin
          if (!init_done) early_reads++;
          if (adr == 5'd0) begin
            rbr_cnt++;
            check("rbr_while_held", 32'(rx_valid), 0);
          end
        end
        if (adr == 5'd0 && init_done) acc_log.push_back(we ? 2 : 1);
      end
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_rx: got %0h expected none", rx_data);
        end else check("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (tx_ready) begin
        txr_cnt++;
        check("tx_ready_one_cycle", 32'(prev_txr), 0);
      end
      prev_txr = tx_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    exp_wr.push_back({5'd3, 8'h83});
    exp_wr.push_back({5'd0, 8'h1B});
    exp_wr.push_back({5'd1, 8'h00});
    exp_wr.push_back({5'd3, 8'h03});
    exp_wr.push_back({5'd2, 8'h07});
  endtask

  task automatic check_reset();
    check("rst_cyc", 32'(cyc), 0);
    check("rst_stb", 32'(stb), 0);
    check("rst_we", 32'(we), 0);
    check("rst_adr", 32'(adr), 0);
    check("rst_dat", dat_o, 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_timeout", 32'(timeout), 0);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 600 && !init_done; i++) tick();
    check("init_done", 32'(init_done), 1);
    check("no_early_reads", 32'(early_reads), 0);
    check("init_writes_done", 32'(exp_wr.size()), 0);
  endtask

  task automatic send_tx(input logic [7:0] b);
    exp_wr.push_back({5'd0, b});
    tx_sent.push_back(b);
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 600 && !tx_ready; i++) tick();
    check("tx_ready_seen", 32'(tx_ready), 1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drain_rx();
    for (int i = 0; i < 2000 && exp_rx.size() > 0; i++) tick();
    check("rx_drained", 32'(exp_rx.size()), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, b2;
    int n, c;
    #23;
    check_reset();
`ifdef UART16550_SEQ_ACK_TIMEOUT_EN
    no_ack = 1;
`endif
    push_init();
    tick();
    rst_n = 1'b1;
`ifdef UART16550_SEQ_ACK_TIMEOUT_EN
    for (int i = 0; i < 50 && !cyc; i++) tick();
    n = 0;
    while (cyc && n < 100) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 16);
    check("timeout_flag", 32'(timeout), 1);
    tick();
    check("retry_cyc", 32'(cyc), 1);
    check("retry_write", 32'({adr, dat_o[7:0]}), 32'({5'd3, 8'h83}));
    no_ack = 0;
`endif
    wait_init();
    check("overrun_clear", 32'(overrun), 0);
    send_tx(8'h55);
    for (int k = 0; k < 5; k++) send_tx(8'($urandom));
    check("tx_ready_count", 32'(txr_cnt), 6);
    check("thr_first", 32'(thr_log.size() > 0 ? thr_log[0] : 8'h00), 32'h55);
    // held byte: no RBR read while rx_valid stays high
    rx_ready = 1'b0;
    rx_fifo.push_back(8'hA5);
    rx_fifo.push_back(8'h3C);
    exp_rx.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    for (int i = 0; i < 400 && !rx_valid; i++) tick();
    check("rx_valid_first", 32'(rx_valid), 1);
    check("rx_data_first", 32'(rx_data), 32'hA5);
    c = rbr_cnt;
    repeat (60) tick();
    check("no_rbr_while_held", 32'(rbr_cnt), 32'(c));
    check("uart_fifo_holds", 32'(rx_fifo.size()), 1);
    check("rx_still_valid", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    for (int i = 0; i < 400 && !rx_valid; i++) tick();
    check("rx_data_second", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    drain_rx();
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      rx_fifo.push_back(b);
      exp_rx.push_back(b);
    end
    drain_rx();
    // both directions pending at the same poll
    no_ack = 1;
    repeat (3) tick();
    acc_log.delete();
    b = 8'($urandom);
    b2 = 8'($urandom);
    rx_fifo.push_back(b);
    exp_rx.push_back(b);
    exp_wr.push_back({5'd0, b2});
    tx_sent.push_back(b2);
    tx_data = b2;
    tx_valid = 1'b1;
    no_ack = 0;
    for (int i = 0; i < 600 && !tx_ready; i++) tick();
    check("prio_tx_done", 32'(tx_ready), 1);
    tick();
    tx_valid = 1'b0;
    drain_rx();
    check("prio_two_accesses", 32'(acc_log.size() >= 2), 1);
    if (acc_log.size() >= 2) begin
      check("prio_rbr_first", 32'(acc_log[0]), 1);
      check("prio_thr_second", 32'(acc_log[1]), 2);
    end
    // overrun is sticky
    force_oe = 1;
    for (int i = 0; i < 300 && !overrun; i++) tick();
    check("overrun_set", 32'(overrun), 1);
    force_oe = 0;
    repeat (40) tick();
    check("overrun_sticky", 32'(overrun), 1);
    // reset in the middle of a THR write
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    for (int i = 0; i < 600 && !(cyc && we && adr == 5'd0); i++) tick();
    check("thr_write_in_flight", 32'(stb && we && adr == 5'd0), 1);
    n = thr_log.size();
    rst_n = 1'b0;
    #1;
    check_reset();
    tx_valid = 1'b0;
    push_init();
    tick();
    tick();
    rst_n = 1'b1;
    wait_init();
    check("aborted_not_written", 32'(thr_log.size()), 32'(n));
    check("thr_count", 32'(thr_log.size()), 32'(tx_sent.size()));
    for (int k = 0; k < thr_log.size() && k < tx_sent.size(); k++) check("thr_byte", 32'(thr_log[k]), 32'(tx_sent[k]));
    check("exp_wr_empty", 32'(exp_wr.size()), 0);
`ifndef UART16550_SEQ_ACK_TIMEOUT_EN
    check("timeout_tied", 32'(timeout), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
